hack_keyboard: RTL



---
 rtl/hack_keyboard.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/hack_keyboard.sv
// PS/2 set-2 keyboard receiver and Hack keyboard-code decoder (memory-mapped at 0x6000).
// Optional feature macro: KBD_SHIFT_EN (shift-aware letter codes).
module hack_keyboard #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] kbd_out,
  output logic        key_event,
  output logic        frame_error
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic [FW-1:0] flt_cnt;
  logic          clk_filt, fall;
  logic          data_s;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] to_q, to_d;
  logic          err_d, byte_vld_q, byte_vld_d;
  logic          timeout_hit;

  logic          ext, brk;
  logic [8:0]    held;
  logic [7:0]    code_c, lbase;
  logic          is_shift;

  assign data_s = data_sync[1];

  // 2-FF synchronizers; idle bus level is high
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Glitch filter: follow the synchronized clock only after FILTER_LEN differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      flt_cnt  <= '0;
      clk_filt <= 1'b1;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_cnt  <= '0;
        clk_filt <= clk_sync[1];
        fall     <= clk_filt;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      par_ok_q    <= 1'b0;
      to_q        <= '0;
      byte_vld_q  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      par_ok_q    <= par_ok_d;
      to_q        <= to_d;
      byte_vld_q  <= byte_vld_d;
      frame_error <= err_d;
    end
  end

  // Frame receiver; a timeout takes priority over a coincident fall
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    par_ok_d    = par_ok_q;
    to_d        = (state_q == IDLE) ? '0 : to_q + TW'(1);
    err_d       = 1'b0;
    byte_vld_d  = 1'b0;
    timeout_hit = (state_q != IDLE) && (to_q == TW'(TIMEOUT_CYCLES - 1));
    if (timeout_hit) begin
      state_d = IDLE;
      to_d    = '0;
      err_d   = 1'b1;
    end else if (fall) begin
      to_d = '0;
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d = DATA;
            bit_d   = '0;
            shift_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d = {data_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = ^{shift_q, data_s};
          state_d  = STOP;
        end
        STOP: begin
          if (data_s && par_ok_q) byte_vld_d = 1'b1;
          else                    err_d      = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef KBD_SHIFT_EN
  logic shift_held;
  assign is_shift = !ext && (shift_q == 8'h12 || shift_q == 8'h59);
  assign lbase    = shift_held ? 8'd65 : 8'd97;

  always_ff @(posedge clk) begin
    if (reset)                                  shift_held <= 1'b0;
    else if (byte_vld_q && is_shift && shift_q != 8'hE0 && shift_q != 8'hF0)
                                                shift_held <= ~brk;
  end
`else
  assign is_shift = 1'b0;
  assign lbase    = 8'd65;
`endif

  // Scan-code set 2 lookup; zero means unmapped
  always_comb begin
    code_c = '0;
    case ({ext, shift_q})
      9'h01C: code_c = lbase + 8'd0;   9'h032: code_c = lbase + 8'd1;
      9'h021: code_c = lbase + 8'd2;   9'h023: code_c = lbase + 8'd3;
      9'h024: code_c = lbase + 8'd4;   9'h02B: code_c = lbase + 8'd5;
      9'h034: code_c = lbase + 8'd6;   9'h033: code_c = lbase + 8'd7;
      9'h043: code_c = lbase + 8'd8;   9'h03B: code_c = lbase + 8'd9;
      9'h042: code_c = lbase + 8'd10;  9'h04B: code_c = lbase + 8'd11;
      9'h03A: code_c = lbase + 8'd12;  9'h031: code_c = lbase + 8'd13;
      9'h044: code_c = lbase + 8'd14;  9'h04D: code_c = lbase + 8'd15;
      9'h015: code_c = lbase + 8'd16;  9'h02D: code_c = lbase + 8'd17;
      9'h01B: code_c = lbase + 8'd18;  9'h02C: code_c = lbase + 8'd19;
      9'h03C: code_c = lbase + 8'd20;  9'h02A: code_c = lbase + 8'd21;
      9'h01D: code_c = lbase + 8'd22;  9'h022: code_c = lbase + 8'd23;
      9'h035: code_c = lbase + 8'd24;  9'h01A: code_c = lbase + 8'd25;
      9'h045: code_c = 8'd48;  9'h016: code_c = 8'd49;  9'h01E: code_c = 8'd50;
      9'h026: code_c = 8'd51;  9'h025: code_c = 8'd52;  9'h02E: code_c = 8'd53;
      9'h036: code_c = 8'd54;  9'h03D: code_c = 8'd55;  9'h03E: code_c = 8'd56;
      9'h046: code_c = 8'd57;
      9'h029: code_c = 8'd32;  9'h05A: code_c = 8'd128; 9'h066: code_c = 8'd129;
      9'h076: code_c = 8'd140;
      9'h16B: code_c = 8'd130; 9'h175: code_c = 8'd131; 9'h174: code_c = 8'd132;
      9'h172: code_c = 8'd133;
      default: code_c = '0;
    endcase
  end

  // Make/break/prefix tracking; held == 0 means no key held
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_out   <= '0;
      key_event <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      held      <= '0;
    end else begin
      key_event <= 1'b0;
      if (byte_vld_q) begin
        if (shift_q == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!is_shift) begin
            if (brk) begin
              if ({ext, shift_q} == held) begin
                kbd_out   <= '0;
                held      <= '0;
                key_event <= (kbd_out != 16'd0);
              end
            end else if (code_c != 8'd0 && {ext, shift_q} != held) begin
              kbd_out   <= 16'(code_c);
              held      <= {ext, shift_q};
              key_event <= (kbd_out != 16'(code_c));
            end
          end
        end
      end
    end
  end

endmodule
